// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment time display: active-low segment
// patterns {g,f,e,d,c,b,a}, scan slot indices and the all-off anode word.
package seg7_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] IDX_S1 = 3'd0;
  localparam logic [2:0] IDX_S2 = 3'd1;
  localparam logic [2:0] IDX_M1 = 3'd2;
  localparam logic [2:0] IDX_M2 = 3'd3;
  localparam logic [2:0] IDX_H1 = 3'd4;
  localparam logic [2:0] IDX_H2 = 3'd5;

  localparam logic [5:0] AN_ALL_OFF = 6'b111111;

endpackage

// File: rtl/seg7_time_display_if.sv
// Digit inputs and display pins of the time display; master is the
// time source / board side, slave is the display driver.
interface seg7_time_display_if;
  logic       en;
  logic [3:0] s1, s2, m1, m2, h1, h2;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output en, s1, s2, m1, m2, h1, h2, input an, seg, dp);
  modport slave  (input en, s1, s2, m1, m2, h1, h2, output an, seg, dp);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal
// codes show a dash so a corrupt digit is visible rather than silent.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // pattern lookup, blank overrides the digit
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_time_display.sv
// Scans six snapshotted BCD digits onto a common-anode display and blinks
// the minute/hour separator points; all pin outputs are registered.
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLINK_TICKS = 50_000_000,
  parameter bit BLANK_H2    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_time_display_if.slave  bus
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [TW-1:0]   tick_r;
  logic [2:0]      idx_r;
  logic [BW-1:0]   blink_cnt_r;
  logic            blink_r;
  logic [5:0][3:0] snap_r;
  logic [5:0]      an_r;
  logic [6:0]      seg_r;
  logic            dp_r;

  logic            tick_end_s;
  logic            blink_end_s;
  logic [3:0]      digit_s;
  logic            blank_s;
  logic [6:0]      seg_s;

  assign tick_end_s  = (tick_r == TW'(DIGIT_TICKS - 1));
  assign blink_end_s = (blink_cnt_r == BW'(BLINK_TICKS - 1));

  // slot timer and scan index; both keep running while the display is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r <= '0;
      idx_r  <= IDX_S1;
    end else if (tick_end_s) begin
      tick_r <= '0;
      idx_r  <= (idx_r == IDX_H2) ? IDX_S1 : idx_r + 3'd1;
    end else begin
      tick_r <= tick_r + TW'(1);
    end
  end

  // frame snapshot, loaded as the scan wraps so every frame shows one coherent time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r <= '0;
    end else if (tick_end_s && (idx_r == IDX_H2)) begin
      snap_r <= {bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1};
    end else begin
      snap_r <= snap_r;
    end
  end

  // separator blink timebase, independent of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_r     <= 1'b0;
    end else if (blink_end_s) begin
      blink_cnt_r <= '0;
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1);
    end
  end

  // digit select for the current slot
  always_comb begin
    digit_s = 4'd0;
    case (idx_r)
      IDX_S1:  digit_s = snap_r[0];
      IDX_S2:  digit_s = snap_r[1];
      IDX_M1:  digit_s = snap_r[2];
      IDX_M2:  digit_s = snap_r[3];
      IDX_H1:  digit_s = snap_r[4];
      IDX_H2:  digit_s = snap_r[5];
      default: digit_s = 4'd0;
    endcase
  end

  assign blank_s = BLANK_H2 && (idx_r == IDX_H2) && (snap_r[5] == 4'd0);

  bcd_to_seg7 u_dec (
    .bcd   (digit_s),
    .blank (blank_s),
    .seg   (seg_s)
  );

  // registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= AN_ALL_OFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= bus.en ? ~(6'b000001 << idx_r) : AN_ALL_OFF;
      seg_r <= seg_s;
      dp_r  <= ~(bus.en && blink_r && ((idx_r == IDX_M1) || (idx_r == IDX_H1)));
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.dp  = dp_r;

endmodule
